// File: rtl/rob_commit_unit.sv
// Reorder-buffer commit unit: in-order allocation, out-of-order result capture
// from the common data bus, in-order single-entry retirement to the register bank.
module rob_commit_unit #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 3,
  parameter int REG_W   = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]    count,
  input  logic              flush
);

  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(ENTRIES);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_ready;
  logic [REG_W-1:0]   ent_dest [ENTRIES];
  logic [DATA_W-1:0]  ent_data [ENTRIES];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic do_alloc;
  logic do_commit;
  logic cdb_hit;

  assign alloc_ready = (count < CNT_FULL);
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = ent_valid[head] && ent_ready[head];

  // A broadcast aimed at the slot being (re)allocated this edge belongs to a
  // stale producer, so it is dropped rather than marking the new entry ready.
  assign cdb_hit = cdb_valid && ent_valid[cdb_tag] && !ent_ready[cdb_tag] &&
                   !(do_alloc && (cdb_tag == tail));

  always_ff @(posedge clk1) begin
    if (!rst_n || flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_dest  <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
      ent_valid    <= '0;
      ent_ready    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_dest[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      commit_valid <= do_commit;

      // head and tail only coincide when empty or full, so commit and
      // allocation never touch the same slot on one edge.
      if (do_commit) begin
        commit_dest     <= ent_dest[head];
        commit_data     <= ent_data[head];
        commit_tag      <= head;
        ent_valid[head] <= 1'b0;
        ent_ready[head] <= 1'b0;
        head            <= head + PTR_ONE;
      end

      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
        ent_dest[tail]  <= alloc_dest;
        ent_data[tail]  <= '0;
        tail            <= tail + PTR_ONE;
      end

      if (cdb_hit) begin
        ent_ready[cdb_tag] <= 1'b1;
        ent_data[cdb_tag]  <= cdb_data;
      end

      case ({do_alloc, do_commit})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed self-checking bench for rob_commit_unit; inputs driven and outputs
// sampled 1ns after each rising edge.
module tb_rob_commit_unit;

  logic        clk1;
  logic        rst_n;
  logic        alloc_valid;
  logic [3:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        commit_valid;
  logic [3:0]  commit_dest;
  logic [15:0] commit_data;
  logic [2:0]  commit_tag;
  logic [3:0]  count;
  logic        flush;

  int errors = 0;
  int checks = 0;

  rob_commit_unit #(.ENTRIES(8), .TAG_W(3), .REG_W(4), .DATA_W(16)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count), .flush(flush)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_dest = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; alloc_valid = 1; alloc_dest = 4'd9; cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'hDEAD; flush = 0;
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready); end
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== 24'd0) begin errors++;
      $display("FAIL reset_commit got v=%b d=%0d data=%h t=%0d exp all 0", commit_valid, commit_dest, commit_data, commit_tag); end
    idle(); rst_n = 1;
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc_valid = 1; alloc_dest = 4'd3;
    checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL ooo_tag0 got=%0d exp=0", alloc_tag); end
    step();
    alloc_dest = 4'd5;
    checks++; if (alloc_tag !== 3'd1) begin errors++; $display("FAIL ooo_tag1 got=%0d exp=1", alloc_tag); end
    step();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL ooo_count2 got=%0d exp=2", count); end
    idle(); cdb_valid = 1; cdb_tag = 3'd1; cdb_data = 16'h0022;
    step();
    cdb_tag = 3'd0; cdb_data = 16'h0011;
    step();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_early_commit got=%b exp=0", commit_valid); end
    idle();
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd3, 16'h0011, 3'd0}) begin errors++;
      $display("FAIL ooo_commit0 got v=%b d=%0d data=%h t=%0d exp v=1 d=3 data=0011 t=0", commit_valid, commit_dest, commit_data, commit_tag); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL ooo_count1 got=%0d exp=1", count); end
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd5, 16'h0022, 3'd1}) begin errors++;
      $display("FAIL ooo_commit1 got v=%b d=%0d data=%h t=%0d exp v=1 d=5 data=0022 t=1", commit_valid, commit_dest, commit_data, commit_tag); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL ooo_count0 got=%0d exp=0", count); end
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b0, 4'd5, 16'h0022, 3'd1}) begin errors++;
      $display("FAIL ooo_hold got v=%b d=%0d data=%h t=%0d exp v=0 d=5 data=0022 t=1", commit_valid, commit_dest, commit_data, commit_tag); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_dest = 4'(i + 1);
      step();
    end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count8 got=%0d exp=8", count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready got=%b exp=0", alloc_ready); end
    alloc_dest = 4'd15;
    step();
    checks++; if (count !== 4'd8 || alloc_tag !== 3'd0) begin errors++;
      $display("FAIL full_ninth_ignored got count=%0d tag=%0d exp count=8 tag=0", count, alloc_tag); end
    idle(); cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'h00A0;
    step();
    idle();
    step();
    checks++; if ({commit_valid, commit_dest, commit_data} !== {1'b1, 4'd1, 16'h00A0}) begin errors++;
      $display("FAIL full_commit got v=%b d=%0d data=%h exp v=1 d=1 data=00a0", commit_valid, commit_dest, commit_data); end
    checks++; if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin errors++;
      $display("FAIL full_after_commit got count=%0d ready=%b tag=%0d exp 7 1 0", count, alloc_ready, alloc_tag); end
    alloc_valid = 1; alloc_dest = 4'd12;
    step();
    checks++; if (count !== 4'd8 || alloc_ready !== 1'b0 || alloc_tag !== 3'd1) begin errors++;
      $display("FAIL full_wrap_alloc got count=%0d ready=%b tag=%0d exp 8 0 1", count, alloc_ready, alloc_tag); end
    idle();
  endtask

  task automatic test_cdb_ignore();
    do_reset();
    cdb_valid = 1; cdb_tag = 3'd4; cdb_data = 16'h0044;
    step();
    idle();
    step();
    checks++; if (count !== 4'd0 || commit_valid !== 1'b0 || alloc_tag !== 3'd0) begin errors++;
      $display("FAIL ign_invalid_tag got count=%0d cv=%b tag=%0d exp 0 0 0", count, commit_valid, alloc_tag); end
    alloc_valid = 1; alloc_dest = 4'd7;
    step();
    alloc_dest = 4'd9;
    step();
    idle(); cdb_valid = 1; cdb_tag = 3'd1; cdb_data = 16'h005A;
    step();
    cdb_data = 16'h00FF;
    step();
    cdb_tag = 3'd0; cdb_data = 16'h0011;
    step();
    idle();
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd7, 16'h0011, 3'd0}) begin errors++;
      $display("FAIL ign_commit0 got v=%b d=%0d data=%h t=%0d exp v=1 d=7 data=0011 t=0", commit_valid, commit_dest, commit_data, commit_tag); end
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd9, 16'h005A, 3'd1}) begin errors++;
      $display("FAIL ign_repeat_cdb got v=%b d=%0d data=%h t=%0d exp v=1 d=9 data=005a t=1", commit_valid, commit_dest, commit_data, commit_tag); end
  endtask

  task automatic test_full_commit_alloc();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_dest = 4'(i);
      step();
    end
    idle(); cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'h0033;
    step();
    idle(); alloc_valid = 1; alloc_dest = 4'd15;
    step();
    checks++; if ({commit_valid, commit_tag, commit_data} !== {1'b1, 3'd0, 16'h0033}) begin errors++;
      $display("FAIL fca_commit got v=%b t=%0d data=%h exp v=1 t=0 data=0033", commit_valid, commit_tag, commit_data); end
    checks++; if (count !== 4'd7 || alloc_tag !== 3'd0) begin errors++;
      $display("FAIL fca_alloc_rejected got count=%0d tag=%0d exp count=7 tag=0", count, alloc_tag); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_valid = 1; alloc_dest = 4'd2;
    step();
    alloc_dest = 4'd4;
    step();
    idle(); cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'h0010;
    step();
    alloc_valid = 1; alloc_dest = 4'd6; cdb_tag = 3'd1; cdb_data = 16'h0020;
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd2, 16'h0010, 3'd0} || count !== 4'd2) begin errors++;
      $display("FAIL b2b_first got v=%b d=%0d data=%h t=%0d count=%0d exp v=1 d=2 data=0010 t=0 count=2", commit_valid, commit_dest, commit_data, commit_tag, count); end
    alloc_dest = 4'd8; cdb_tag = 3'd3; cdb_data = 16'h0099;
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd4, 16'h0020, 3'd1} || count !== 4'd2) begin errors++;
      $display("FAIL b2b_second got v=%b d=%0d data=%h t=%0d count=%0d exp v=1 d=4 data=0020 t=1 count=2", commit_valid, commit_dest, commit_data, commit_tag, count); end
    idle(); cdb_valid = 1; cdb_tag = 3'd2; cdb_data = 16'h0030;
    step();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", commit_valid); end
    idle();
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd6, 16'h0030, 3'd2} || count !== 4'd1) begin errors++;
      $display("FAIL b2b_third got v=%b d=%0d data=%h t=%0d count=%0d exp v=1 d=6 data=0030 t=2 count=1", commit_valid, commit_dest, commit_data, commit_tag, count); end
    step();
    checks++; if (commit_valid !== 1'b0 || count !== 4'd1) begin errors++;
      $display("FAIL b2b_same_edge_cdb_ignored got v=%b count=%0d exp v=0 count=1", commit_valid, count); end
    cdb_valid = 1; cdb_tag = 3'd3; cdb_data = 16'h0040;
    step();
    idle();
    step();
    checks++; if ({commit_valid, commit_dest, commit_data, commit_tag} !== {1'b1, 4'd8, 16'h0040, 3'd3} || count !== 4'd0) begin errors++;
      $display("FAIL b2b_fourth got v=%b d=%0d data=%h t=%0d count=%0d exp v=1 d=8 data=0040 t=3 count=0", commit_valid, commit_dest, commit_data, commit_tag, count); end
  endtask

  // use_rst selects between flush and rst_n as the clearing input
  task automatic test_flush(input bit use_rst);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_dest = 4'(i + 10);
      step();
    end
    idle(); cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'h0077;
    step();
    alloc_valid = 1; alloc_dest = 4'd1; cdb_tag = 3'd1; cdb_data = 16'h0088;
    if (use_rst) rst_n = 0; else flush = 1;
    step();
    checks++; if (count !== 4'd0 || commit_valid !== 1'b0 || alloc_tag !== 3'd0 || commit_data !== 16'h0) begin errors++;
      $display("FAIL clear_%s got count=%0d cv=%b tag=%0d data=%h exp 0 0 0 0000", use_rst ? "rst" : "flush", count, commit_valid, alloc_tag, commit_data); end
    idle(); rst_n = 1;
    step();
    step();
    checks++; if (count !== 4'd0 || commit_valid !== 1'b0) begin errors++;
      $display("FAIL clear_%s_entries got count=%0d cv=%b exp 0 0", use_rst ? "rst" : "flush", count, commit_valid); end
  endtask

  initial begin
    idle(); rst_n = 0;
    test_reset();
    test_out_of_order();
    test_full_wrap();
    test_cdb_ignore();
    test_full_commit_alloc();
    test_back_to_back();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
